// File: rtl/mp3_pkg.sv
// Constants for MPEG-1 Layer III header detection: sync pattern, header field
// positions, bitrate/sample-rate tables and the precomputed frame-size table.
package mp3_pkg;

    localparam int unsigned SYNC_W   = 11;
    localparam logic [SYNC_W-1:0] SYNC = 11'h7FF;

    // Header bit positions within the 32-bit header word
    localparam int unsigned SYNC_HI  = 31;
    localparam int unsigned SYNC_LO  = 21;
    localparam int unsigned VER_HI   = 20;
    localparam int unsigned VER_LO   = 19;
    localparam int unsigned LAYER_HI = 18;
    localparam int unsigned LAYER_LO = 17;
    localparam int unsigned PROT_BIT = 16;
    localparam int unsigned BR_HI    = 15;
    localparam int unsigned BR_LO    = 12;
    localparam int unsigned SR_HI    = 11;
    localparam int unsigned SR_LO    = 10;
    localparam int unsigned PAD_BIT  = 9;
    localparam int unsigned MODE_HI  = 7;
    localparam int unsigned MODE_LO  = 6;
    localparam int unsigned EXT_HI   = 5;
    localparam int unsigned EXT_LO   = 4;
    localparam int unsigned EMPH_HI  = 1;
    localparam int unsigned EMPH_LO  = 0;

    localparam logic [1:0] VER_MPEG1   = 2'b11;
    localparam logic [1:0] LAYER_III   = 2'b01;
    localparam logic [3:0] BR_FREE     = 4'b0000;
    localparam logic [3:0] BR_BAD      = 4'b1111;
    localparam logic [1:0] SR_RESERVED = 2'b11;
    localparam logic [1:0] EMPH_RSVD   = 2'b10;

    localparam int unsigned FS_W = 11;

    // Reference tables; the frame-size tables below are derived from these
    localparam int unsigned BITRATE_KBPS [0:15] = '{
        0, 32, 40, 48, 56, 64, 80, 96, 112, 128, 160, 192, 224, 256, 320, 0};
    localparam int unsigned SAMPLE_RATE_HZ [0:3] = '{44100, 48000, 32000, 0};

    // floor(144 * bitrate_bps / samplerate_hz), indexed by bitrate index
    localparam logic [FS_W-1:0] FS_44K1 [0:15] = '{
        11'd0,   11'd104, 11'd130, 11'd156, 11'd182, 11'd208, 11'd261, 11'd313,
        11'd365, 11'd417, 11'd522, 11'd626, 11'd731, 11'd835, 11'd1044, 11'd0};
    localparam logic [FS_W-1:0] FS_48K [0:15] = '{
        11'd0,   11'd96,  11'd120, 11'd144, 11'd168, 11'd192, 11'd240, 11'd288,
        11'd336, 11'd384, 11'd480, 11'd576, 11'd672, 11'd768, 11'd960,  11'd0};
    localparam logic [FS_W-1:0] FS_32K [0:15] = '{
        11'd0,   11'd144, 11'd180, 11'd216, 11'd252, 11'd288, 11'd360, 11'd432,
        11'd504, 11'd576, 11'd720, 11'd864, 11'd1008, 11'd1152, 11'd1440, 11'd0};

endpackage

// File: rtl/mp3_frame_size_lut.sv
// Combinational frame-length lookup for MPEG-1 Layer III.
// Ports:
//   br_idx     in  4   bitrate index (1..14 meaningful)
//   sr_idx     in  2   sample-rate index (0..2 meaningful)
//   padding    in  1   padding slot flag, adds one byte
//   frame_size out 11  frame length in bytes including header
module mp3_frame_size_lut
    import mp3_pkg::*;
(
    input  logic [3:0]      br_idx,
    input  logic [1:0]      sr_idx,
    input  logic            padding,
    output logic [FS_W-1:0] frame_size
);

    logic [FS_W-1:0] base_c;

    // Table select by sample rate; reserved rate yields 0 (never matched upstream)
    always_comb begin
        base_c = '0;
        case (sr_idx)
            2'd0:    base_c = FS_44K1[br_idx];
            2'd1:    base_c = FS_48K[br_idx];
            2'd2:    base_c = FS_32K[br_idx];
            default: base_c = '0;
        endcase
    end

    assign frame_size = FS_W'(base_c + FS_W'(padding));

endmodule

// File: rtl/mp3_header_finder.sv
// Byte-aligned MPEG-1 Layer III frame header search and decode.
// Ports:
//   clk, rst       clock; synchronous active-high reset
//   axiid, axiiv   input byte (MSB earliest) and its valid strobe
//   valid_header   one-cycle pulse when a header completes
//   prot, mode, mode_ext, emphasis, frame_size
//                  decoded fields, held until the next match
module mp3_header_finder
    import mp3_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [7:0]      axiid,
    input  logic            axiiv,
    output logic            valid_header,
    output logic            prot,
    output logic [1:0]      mode,
    output logic [1:0]      mode_ext,
    output logic [1:0]      emphasis,
    output logic [FS_W-1:0] frame_size
);

    logic [31:0]     sr;
    logic [31:0]     nxt_c;
    logic            match_c;
    logic [FS_W-1:0] fs_c;

    // Candidate header word including the byte on the bus this cycle
    assign nxt_c = {sr[23:0], axiid};

    always_comb begin
        match_c = axiiv
               && (nxt_c[SYNC_HI:SYNC_LO]   == SYNC)
               && (nxt_c[VER_HI:VER_LO]     == VER_MPEG1)
               && (nxt_c[LAYER_HI:LAYER_LO] == LAYER_III)
               && (nxt_c[BR_HI:BR_LO]       != BR_FREE)
               && (nxt_c[BR_HI:BR_LO]       != BR_BAD)
               && (nxt_c[SR_HI:SR_LO]       != SR_RESERVED)
               && (nxt_c[EMPH_HI:EMPH_LO]   != EMPH_RSVD);
    end

    mp3_frame_size_lut u_lut (
        .br_idx     (nxt_c[BR_HI:BR_LO]),
        .sr_idx     (nxt_c[SR_HI:SR_LO]),
        .padding    (nxt_c[PAD_BIT]),
        .frame_size (fs_c)
    );

    // Shift register and output capture; a match flushes sr so it cannot re-fire
    always_ff @(posedge clk) begin
        if (rst) begin
            sr           <= '0;
            valid_header <= 1'b0;
            prot         <= 1'b0;
            mode         <= '0;
            mode_ext     <= '0;
            emphasis     <= '0;
            frame_size   <= '0;
        end else begin
            valid_header <= 1'b0;
            if (axiiv) begin
                if (match_c) begin
                    sr           <= '0;
                    valid_header <= 1'b1;
                    prot         <= nxt_c[PROT_BIT];
                    mode         <= nxt_c[MODE_HI:MODE_LO];
                    mode_ext     <= nxt_c[EXT_HI:EXT_LO];
                    emphasis     <= nxt_c[EMPH_HI:EMPH_LO];
                    frame_size   <= fs_c;
                end else begin
                    sr <= nxt_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_mp3_header_finder.sv
// Directed bench for mp3_header_finder with hand-computed expected fields.
module tb_mp3_header_finder;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  axiid;
    logic        axiiv;
    logic        valid_header;
    logic        prot;
    logic [1:0]  mode;
    logic [1:0]  mode_ext;
    logic [1:0]  emphasis;
    logic [10:0] frame_size;

    int n_vec = 0;
    int n_err = 0;
    int pulses = 0;

    always #5 clk = ~clk;

    mp3_header_finder dut (
        .clk          (clk),
        .rst          (rst),
        .axiid        (axiid),
        .axiiv        (axiiv),
        .valid_header (valid_header),
        .prot         (prot),
        .mode         (mode),
        .mode_ext     (mode_ext),
        .emphasis     (emphasis),
        .frame_size   (frame_size)
    );

    always @(posedge clk) if (valid_header === 1'b1) pulses++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one byte for one cycle; vh is valid_header the cycle after acceptance
    task automatic send_byte(input logic [7:0] b, input int gap, output logic vh);
        @(negedge clk);
        axiid = b;
        axiiv = 1'b1;
        @(negedge clk);
        axiiv = 1'b0;
        axiid = 8'h00;
        vh = valid_header;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_hdr(input string tag, input logic [31:0] h, input int gap, input logic hit);
        logic vh;
        int   p0;
        p0 = pulses;
        for (int i = 0; i < 4; i++) begin
            send_byte(h[31-8*i -: 8], gap, vh);
            if (i < 3) check({tag, "_early"}, 32'(vh), 32'd0);
            else       check({tag, "_pulse"}, 32'(vh), 32'(hit));
        end
        repeat (2) @(negedge clk);
        check({tag, "_npulse"}, 32'(pulses - p0), hit ? 32'd1 : 32'd0);
    endtask

    task automatic check_fields(input string tag, input logic p, input logic [1:0] m,
                                input logic [1:0] x, input logic [1:0] e, input logic [10:0] fs);
        check({tag, "_prot"}, 32'(prot), 32'(p));
        check({tag, "_mode"}, 32'(mode), 32'(m));
        check({tag, "_ext"},  32'(mode_ext), 32'(x));
        check({tag, "_emph"}, 32'(emphasis), 32'(e));
        check({tag, "_fs"},   32'(frame_size), 32'(fs));
    endtask

    initial begin
        logic vh;
        int   p0;
        rst = 1'b1; axiid = 8'h00; axiiv = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_vh", 32'(valid_header), 32'd0);
        check_fields("rst", 1'b0, 2'd0, 2'd0, 2'd0, 11'd0);

        // Reset mid-header, with a byte on the bus during reset
        p0 = pulses;
        send_byte(8'hFF, 1, vh);
        send_byte(8'hFB, 1, vh);
        @(negedge clk);
        rst = 1'b1; axiiv = 1'b1; axiid = 8'h92;
        @(negedge clk);
        rst = 1'b0; axiiv = 1'b0; axiid = 8'h00;
        send_byte(8'h92, 1, vh);
        send_byte(8'h64, 1, vh);
        check("rstmid_vh", 32'(vh), 32'd0);
        check("rstmid_np", 32'(pulses - p0), 32'd0);
        check_fields("rstmid", 1'b0, 2'd0, 2'd0, 2'd0, 11'd0);

        // 128 kbps, 44.1 kHz, padded
        send_hdr("t1", 32'hFFFB9264, 5, 1'b1);
        check_fields("t1", 1'b1, 2'b01, 2'b10, 2'b00, 11'd418);

        // Leading junk byte, uneven gaps
        p0 = pulses;
        send_byte(8'hCF, 2, vh);
        check("t2_junk", 32'(vh), 32'd0);
        send_byte(8'hFF, 0, vh);
        send_byte(8'hFB, 3, vh);
        send_byte(8'h92, 1, vh);
        send_byte(8'h64, 4, vh);
        check("t2_pulse", 32'(vh), 32'd1);
        check("t2_np", 32'(pulses - p0), 32'd1);
        check_fields("t2", 1'b1, 2'b01, 2'b10, 2'b00, 11'd418);

        // 320 kbps at 32 kHz, without and with padding; then 44.1 kHz
        send_hdr("t3a", 32'hFFFBE800, 1, 1'b1);
        check_fields("t3a", 1'b1, 2'b00, 2'b00, 2'b00, 11'd1440);
        send_hdr("t3b", 32'hFFFBEA00, 0, 1'b1);
        check_fields("t3b", 1'b1, 2'b00, 2'b00, 2'b00, 11'd1441);
        send_hdr("t3c", 32'hFFFBE000, 2, 1'b1);
        check_fields("t3c", 1'b1, 2'b00, 2'b00, 2'b00, 11'd1044);

        // CRC present, 32 kHz padded, mono, emphasis 01
        send_hdr("t3d", 32'hFFFA9BC5, 1, 1'b1);
        check_fields("t3d", 1'b0, 2'b11, 2'b00, 2'b01, 11'd577);

        // 32 kbps at 48 kHz
        send_hdr("t4", 32'hFFFB1400, 1, 1'b1);
        check_fields("t4", 1'b1, 2'b00, 2'b00, 2'b00, 11'd96);

        // Invalid headers: no pulse, fields unchanged
        send_hdr("bad_br", 32'hFFFBF264, 1, 1'b0);
        send_hdr("bad_sr", 32'hFFFB9C64, 1, 1'b0);
        send_hdr("bad_em", 32'hFFFB9266, 1, 1'b0);
        send_hdr("bad_v2", 32'hFFF39264, 1, 1'b0);
        send_hdr("bad_fr", 32'hFFFB0264, 1, 1'b0);
        check_fields("t5", 1'b1, 2'b00, 2'b00, 2'b00, 11'd96);

        // A valid header right after invalid residue still decodes
        send_hdr("t6", 32'hFFFB9264, 0, 1'b1);
        check_fields("t6", 1'b1, 2'b01, 2'b10, 2'b00, 11'd418);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
